// File: rtl/bit_counter_pkg.sv
// Shared definitions for the pipelined bit-counting unit.
// Optional feature macro: BIT_COUNTER_POPCNT_EN enables the population count mode.
package bit_counter_pkg;

    typedef logic [2:0] bc_mode_t;

    localparam bc_mode_t BC_MODE_CLZ    = 3'd0;
    localparam bc_mode_t BC_MODE_CLO    = 3'd1;
    localparam bc_mode_t BC_MODE_CTZ    = 3'd2;
    localparam bc_mode_t BC_MODE_CTO    = 3'd3;
    localparam bc_mode_t BC_MODE_POPCNT = 3'd4;

    // Bits needed to hold a count in 0..width inclusive
    function automatic int bcCountWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_counter_chunk.sv
// Combinational per-chunk counter: leading zeros, all-zero flag and
// (when BIT_COUNTER_POPCNT_EN is defined) the chunk population count.
module bit_counter_chunk
    import bit_counter_pkg::*;
#(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0]                  chunk_i,
    output logic [bcCountWidth(CHUNK_WIDTH)-1:0]    leadZeros_o,
    output logic                                    allZero_o
`ifdef BIT_COUNTER_POPCNT_EN
    ,
    output logic [bcCountWidth(CHUNK_WIDTH)-1:0]    popCount_o
`endif
);

    localparam int CNT_W = bcCountWidth(CHUNK_WIDTH);

    // Scan from the MSB for the first set bit; an empty chunk reports its full width
    always_comb begin
        logic found;
        found       = 1'b0;
        leadZeros_o = CNT_W'(CHUNK_WIDTH);
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (!found && chunk_i[i]) begin
                leadZeros_o = CNT_W'(CHUNK_WIDTH - 1 - i);
                found       = 1'b1;
            end
        end
    end

    assign allZero_o = ~|chunk_i;

`ifdef BIT_COUNTER_POPCNT_EN
    // Number of set bits in the chunk
    always_comb begin
        popCount_o = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            popCount_o = popCount_o + CNT_W'(chunk_i[i]);
        end
    end
`endif

endmodule

// File: rtl/pipelined_bit_counter.sv
// Two-stage pipelined CLZ/CLO/CTZ/CTO (and optional POPCNT) unit with
// valid/ready handshake, tag side channel and flush.
// Optional feature macro: BIT_COUNTER_POPCNT_EN (mode 4 counts set bits;
// without it mode 4 is treated as reserved and returns 0).
module pipelined_bit_counter
    import bit_counter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_mode,
    input  logic [DATA_WIDTH-1:0] in_operand,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = bcCountWidth(DATA_WIDTH);
    localparam int CCNT_W     = bcCountWidth(CHUNK_WIDTH);

    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : gBadDataWidth
        $error("DATA_WIDTH must be a power of two and at least 8");
    end
    if (CHUNK_WIDTH < 1 || (CHUNK_WIDTH & (CHUNK_WIDTH - 1)) != 0) begin : gBadChunkWidth
        $error("CHUNK_WIDTH must be a power of two");
    end
    if (CHUNK_WIDTH > DATA_WIDTH || (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : gBadChunkSplit
        $error("CHUNK_WIDTH must divide DATA_WIDTH");
    end
    if (TAG_WIDTH < 1) begin : gBadTagWidth
        $error("TAG_WIDTH must be at least 1");
    end

    logic                                doInvert;
    logic                                doReverse;
    logic [DATA_WIDTH-1:0]               invOperand;
    logic [DATA_WIDTH-1:0]               normOperand;
    logic [NUM_CHUNKS-1:0][CCNT_W-1:0]   chunkLz;
    logic [NUM_CHUNKS-1:0]               chunkAllZero;

    logic                                s1Valid_q, s1Valid_d;
    bc_mode_t                            s1Mode_q;
    logic [TAG_WIDTH-1:0]                s1Tag_q;
    logic [NUM_CHUNKS-1:0][CCNT_W-1:0]   s1Lz_q;
    logic [NUM_CHUNKS-1:0]               s1AllZero_q;

    logic                                outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0]               outResult_q, outResult_d;
    logic [TAG_WIDTH-1:0]                outTag_q;

    logic                                s2Load;
    logic                                s1Advance;
    logic                                inAccept;
    logic [CNT_W-1:0]                    leadSum;
    logic                                leadFound;

`ifdef BIT_COUNTER_POPCNT_EN
    logic [NUM_CHUNKS-1:0][CCNT_W-1:0]   chunkPop;
    logic [NUM_CHUNKS-1:0][CCNT_W-1:0]   s1Pop_q;
    logic [CNT_W-1:0]                    popSum;
`endif

    assign doInvert  = (in_mode == BC_MODE_CLO) || (in_mode == BC_MODE_CTO);
    assign doReverse = (in_mode == BC_MODE_CTZ) || (in_mode == BC_MODE_CTO);

    // Turn every counting mode into a leading-zero count from the MSB side
    always_comb begin
        invOperand  = doInvert ? ~in_operand : in_operand;
        normOperand = invOperand;
        if (doReverse) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                normOperand[i] = invOperand[DATA_WIDTH - 1 - i];
            end
        end
    end

    for (genvar c = 0; c < NUM_CHUNKS; c++) begin : gChunk
        bit_counter_chunk #(
            .CHUNK_WIDTH (CHUNK_WIDTH)
        ) uChunk (
            .chunk_i     (normOperand[DATA_WIDTH - 1 - c * CHUNK_WIDTH -: CHUNK_WIDTH]),
            .leadZeros_o (chunkLz[c]),
            .allZero_o   (chunkAllZero[c])
`ifdef BIT_COUNTER_POPCNT_EN
            ,
            .popCount_o  (chunkPop[c])
`endif
        );
    end

    assign s2Load    = !outValid_q || out_ready;
    assign s1Advance = s1Valid_q && s2Load;
    assign in_ready  = !rst && !flush && (!s1Valid_q || s2Load);
    assign inAccept  = in_valid && in_ready;

    // Valid bits: flush empties both stages, otherwise data moves when the next stage frees up
    always_comb begin
        s1Valid_d  = s1Valid_q;
        outValid_d = outValid_q;
        if (flush) begin
            s1Valid_d  = 1'b0;
            outValid_d = 1'b0;
        end else begin
            if (s2Load) begin
                outValid_d = s1Valid_q;
            end
            if (inAccept) begin
                s1Valid_d = 1'b1;
            end else if (s1Advance) begin
                s1Valid_d = 1'b0;
            end
        end
    end

    // Stage 1 register: per-chunk partial counts plus mode and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            s1Mode_q    <= '0;
            s1Tag_q     <= '0;
            s1Lz_q      <= '0;
            s1AllZero_q <= '0;
`ifdef BIT_COUNTER_POPCNT_EN
            s1Pop_q     <= '0;
`endif
        end else begin
            s1Valid_q <= s1Valid_d;
            if (inAccept) begin
                s1Mode_q    <= in_mode;
                s1Tag_q     <= in_tag;
                s1Lz_q      <= chunkLz;
                s1AllZero_q <= chunkAllZero;
`ifdef BIT_COUNTER_POPCNT_EN
                s1Pop_q     <= chunkPop;
`endif
            end
        end
    end

    // Combine chunk counts: whole empty chunks add their width until the first non-empty one
    always_comb begin
        leadSum   = '0;
        leadFound = 1'b0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (!leadFound) begin
                if (s1AllZero_q[c]) begin
                    leadSum = leadSum + CNT_W'(CHUNK_WIDTH);
                end else begin
                    leadSum   = leadSum + CNT_W'(s1Lz_q[c]);
                    leadFound = 1'b1;
                end
            end
        end
`ifdef BIT_COUNTER_POPCNT_EN
        popSum = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            popSum = popSum + CNT_W'(s1Pop_q[c]);
        end
`endif
        case (s1Mode_q)
            BC_MODE_CLZ, BC_MODE_CLO, BC_MODE_CTZ, BC_MODE_CTO:
                outResult_d = DATA_WIDTH'(leadSum);
`ifdef BIT_COUNTER_POPCNT_EN
            BC_MODE_POPCNT:
                outResult_d = DATA_WIDTH'(popSum);
`endif
            default:
                outResult_d = '0;
        endcase
    end

    // Output register: loads only when stage 1 hands over, so stalled results hold steady
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outTag_q    <= '0;
        end else begin
            outValid_q <= outValid_d;
            if (s1Advance) begin
                outResult_q <= outResult_d;
                outTag_q    <= s1Tag_q;
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_result = outResult_q;
    assign out_tag    = outTag_q;

endmodule

// File: tb/tb_pipelined_bit_counter.sv
// Scoreboard bench for pipelined_bit_counter: a 32/8 instance with random
// backpressure, flush and reset, plus a 64/16 instance for wide counts.
module tb_pipelined_bit_counter;

    localparam int TW = 5;

    typedef struct {
        logic [63:0]   result;
        logic [TW-1:0] tag;
    } expT;

    logic clk = 1'b0;

    logic          rst, flush, inValid, inReady, outValid, outReady;
    logic [2:0]    inMode;
    logic [31:0]   inOperand, outResult;
    logic [TW-1:0] inTag, outTag;

    logic          wRst, wFlush, wInValid, wInReady, wOutValid, wOutReady;
    logic [2:0]    wInMode;
    logic [63:0]   wInOperand, wOutResult;
    logic [TW-1:0] wInTag, wOutTag;

    expT expQ[$];
    expT wExpQ[$];
    int  checkCount = 0;
    int  missCount  = 0;

    pipelined_bit_counter #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .TAG_WIDTH(TW)) uDut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_mode(inMode),
        .in_operand(inOperand), .in_tag(inTag),
        .out_valid(outValid), .out_ready(outReady),
        .out_result(outResult), .out_tag(outTag)
    );

    pipelined_bit_counter #(.DATA_WIDTH(64), .CHUNK_WIDTH(16), .TAG_WIDTH(TW)) uDutWide (
        .clk(clk), .rst(wRst), .flush(wFlush),
        .in_valid(wInValid), .in_ready(wInReady), .in_mode(wInMode),
        .in_operand(wInOperand), .in_tag(wInTag),
        .out_valid(wOutValid), .out_ready(wOutReady),
        .out_result(wOutResult), .out_tag(wOutTag)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Reference: count directly from the operand bits of a w-bit word
    function automatic logic [63:0] refCount(input logic [2:0] mode, input logic [63:0] op, input int w);
        int n = 0;
        case (mode)
            3'd0: for (int i = w - 1; i >= 0; i--) begin if (op[i])  break; n++; end
            3'd1: for (int i = w - 1; i >= 0; i--) begin if (!op[i]) break; n++; end
            3'd2: for (int i = 0; i < w; i++)      begin if (op[i])  break; n++; end
            3'd3: for (int i = 0; i < w; i++)      begin if (!op[i]) break; n++; end
            3'd4: begin
`ifdef BIT_COUNTER_POPCNT_EN
                for (int i = 0; i < w; i++) n += int'(op[i]);
`endif
            end
            default: n = 0;
        endcase
        return 64'(n);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Offer one operation on the narrow unit for a cycle; record it if accepted
    task automatic applyStimulus(input logic [2:0] mode, input logic [31:0] op, input logic [TW-1:0] tag,
                                 input int readyPct, output logic accepted);
        expT e;
        @(negedge clk);
        inValid   = 1'b1;
        inMode    = mode;
        inOperand = op;
        inTag     = tag;
        outReady  = ($urandom_range(0, 99) < readyPct);
        flush     = 1'b0;
        #1;
        accepted = inReady;
        if (accepted) begin
            e.result = refCount(mode, {32'b0, op}, 32);
            e.tag    = tag;
            expQ.push_back(e);
        end
    endtask

    task automatic issueOp(input logic [2:0] mode, input logic [31:0] op, input logic [TW-1:0] tag, input int readyPct);
        logic acc;
        int   tries = 0;
        do begin
            applyStimulus(mode, op, tag, readyPct, acc);
            tries++;
        end while (!acc && tries < 40);
        if (!acc) begin
            checkCount++;
            missCount++;
            $display("[TB] FAIL accept_timeout: actual=not accepted required=accepted within 40 cycles");
        end
    endtask

    task automatic idleCycle(input logic rdy);
        @(negedge clk);
        inValid  = 1'b0;
        outReady = rdy;
        flush    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
            idleCycle(1'b1);
            #3;
        end
        checkOutput("narrow_drain", 64'(expQ.size()), 64'd0);
    endtask

    task automatic applyWide(input logic [2:0] mode, input logic [63:0] op, input logic [TW-1:0] tag);
        expT e;
        int  tries = 0;
        logic acc = 1'b0;
        while (!acc && tries < 40) begin
            @(negedge clk);
            wInValid   = 1'b1;
            wInMode    = mode;
            wInOperand = op;
            wInTag     = tag;
            #1;
            acc = wInReady;
            tries++;
        end
        if (acc) begin
            e.result = refCount(mode, op, 64);
            e.tag    = tag;
            wExpQ.push_back(e);
        end else begin
            checkCount++;
            missCount++;
            $display("[TB] FAIL wide_accept_timeout: actual=not accepted required=accepted");
        end
    endtask

    // Narrow monitor: a transfer happens at the next edge when valid and ready are both up
    always begin
        @(negedge clk);
        #2;
        if (!rst && !flush && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkCount++;
                missCount++;
                $display("[TB] FAIL unexpected_output: actual result=0x%0h tag=%0d required=no output", outResult, outTag);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("result", 64'(outResult), e.result);
                checkOutput("tag", 64'(outTag), 64'(e.tag));
            end
        end
    end

    // Wide monitor: consumer is always ready
    always begin
        @(negedge clk);
        #2;
        if (!wRst && wOutValid) begin
            if (wExpQ.size() == 0) begin
                checkCount++;
                missCount++;
                $display("[TB] FAIL wide_unexpected_output: actual result=0x%0h required=no output", wOutResult);
            end else begin
                expT e;
                e = wExpQ.pop_front();
                checkOutput("wide_result", wOutResult, e.result);
                checkOutput("wide_tag", 64'(wOutTag), 64'(e.tag));
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        logic        acc;
        logic [63:0] holdRes;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inMode = '0; inOperand = '0; inTag = '0; outReady = 1'b0;
        wRst = 1'b1; wFlush = 1'b0; wInValid = 1'b0; wInMode = '0; wInOperand = '0; wInTag = '0; wOutReady = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(inReady), 64'd0);
        checkOutput("reset_out_valid", 64'(outValid), 64'd0);
        checkOutput("reset_out_result", 64'(outResult), 64'd0);
        checkOutput("reset_out_tag", 64'(outTag), 64'd0);

        @(negedge clk);
        rst = 1'b0; wRst = 1'b0; outReady = 1'b1;
        #1;
        checkOutput("in_ready_after_reset", 64'(inReady), 64'd1);

        $display("[TB] latency check");
        applyStimulus(3'd0, 32'h0001_0000, 5'd3, 100, acc);
        checkOutput("latency_accept", 64'(acc), 64'd1);
        idleCycle(1'b1); #1;
        checkOutput("latency_cycle1_out_valid", 64'(outValid), 64'd0);
        idleCycle(1'b1); #1;
        checkOutput("latency_cycle2_out_valid", 64'(outValid), 64'd1);
        drain();

        $display("[TB] directed vectors");
        issueOp(3'd0, 32'h0000_0000, 5'd1, 100);
        issueOp(3'd0, 32'h8000_0000, 5'd2, 100);
        issueOp(3'd1, 32'hFFFF_FFFF, 5'd4, 100);
        issueOp(3'd2, 32'h8000_0000, 5'd5, 100);
        issueOp(3'd3, 32'h0000_007F, 5'd6, 100);
        issueOp(3'd6, 32'h0000_1234, 5'd7, 100);
        issueOp(3'd4, 32'hF0F0_000F, 5'd8, 100);
        issueOp(3'd2, 32'h0000_0000, 5'd9, 100);
        drain();

        $display("[TB] backpressure");
        applyStimulus(3'd0, 32'h00F0_0000, 5'd10, 100, acc);
        checkOutput("bp_accept1", 64'(acc), 64'd1);
        applyStimulus(3'd2, 32'h0000_0100, 5'd11, 100, acc);
        checkOutput("bp_accept2", 64'(acc), 64'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'd1, 32'hFE00_0000, 5'd12, 0, acc);
            checkOutput("bp_in_ready_low", 64'(acc), 64'd0);
            holdRes = refCount(3'd0, 64'h00F0_0000, 32);
            checkOutput("bp_hold_result", 64'(outResult), holdRes);
            checkOutput("bp_hold_tag", 64'(outTag), 64'd10);
        end
        issueOp(3'd1, 32'hFE00_0000, 5'd12, 100);
        issueOp(3'd3, 32'h0000_0FFF, 5'd13, 100);
        drain();

        $display("[TB] flush");
        applyStimulus(3'd0, 32'h0000_0001, 5'd14, 0, acc);
        checkOutput("flush_fill1", 64'(acc), 64'd1);
        applyStimulus(3'd0, 32'h0000_0002, 5'd15, 0, acc);
        checkOutput("flush_fill2", 64'(acc), 64'd1);
        applyStimulus(3'd0, 32'h0000_0004, 5'd16, 0, acc);
        checkOutput("flush_full_in_ready", 64'(acc), 64'd0);
        @(negedge clk);
        flush = 1'b1; inValid = 1'b1; inMode = 3'd0; inOperand = 32'h0000_0008; inTag = 5'd17; outReady = 1'b1;
        #1;
        checkOutput("flush_cycle_in_ready", 64'(inReady), 64'd0);
        expQ.delete();
        idleCycle(1'b1); #1;
        checkOutput("flush_out_valid_cleared", 64'(outValid), 64'd0);
        idleCycle(1'b1); #1;
        checkOutput("flush_s1_empty", 64'(outValid), 64'd0);
        issueOp(3'd0, 32'h0000_4000, 5'd18, 100);
        drain();

        $display("[TB] reset mid-stream");
        issueOp(3'd0, 32'h0000_0001, 5'd19, 100);
        issueOp(3'd2, 32'h0000_0000, 5'd20, 100);
        issueOp(3'd1, 32'hF000_0000, 5'd21, 100);
        @(negedge clk);
        rst = 1'b1; inValid = 1'b1; outReady = 1'b1;
        #1;
        checkOutput("reset_mid_in_ready", 64'(inReady), 64'd0);
        expQ.delete();
        @(negedge clk);
        #1;
        checkOutput("reset_mid_out_valid", 64'(outValid), 64'd0);
        checkOutput("reset_mid_out_result", 64'(outResult), 64'd0);
        rst = 1'b0; inValid = 1'b0;
        #1;
        checkOutput("reset_mid_in_ready_after", 64'(inReady), 64'd1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            logic [31:0] op;
            int          k;
            k = $urandom_range(0, 31);
            case ($urandom_range(0, 5))
                0:       op = 32'h0;
                1:       op = 32'hFFFF_FFFF;
                2:       op = 32'h1 << k;
                3:       op = ~(32'h1 << k);
                default: op = $urandom;
            endcase
            issueOp(3'($urandom_range(0, 7)), op, TW'($urandom_range(0, 31)), 75);
            if ($urandom_range(0, 7) == 0) idleCycle(1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] wide instance");
        applyWide(3'd0, 64'h1, 5'd1);
        applyWide(3'd2, 64'h0, 5'd2);
        applyWide(3'd1, 64'hFFFF_FFFF_0000_0000, 5'd3);
        applyWide(3'd3, 64'h0000_0000_0001_FFFF, 5'd4);
        for (int n = 0; n < 60; n++) begin
            applyWide(3'($urandom_range(0, 7)), {$urandom, $urandom} >> $urandom_range(0, 63), TW'($urandom_range(0, 31)));
        end
        @(negedge clk);
        wInValid = 1'b0;
        for (int i = 0; i < 20 && wExpQ.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        checkOutput("wide_drain", 64'(wExpQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end

endmodule
